// File: rtl/mest_result_pkg.sv
// Shared types and default sizes for the mest_pro result sink.
package mest_result_pkg;

    localparam int DEFAULT_DATA_WIDTH  = 8;
    localparam int DEFAULT_DEPTH       = 16;
    localparam int DEFAULT_INDEX_WIDTH = 8;
    localparam int DROP_COUNT_WIDTH    = 8;

    typedef enum logic [1:0] {
        COLLECT,
        FLUSH,
        DRAINED
    } result_state_e;

    typedef struct packed {
        logic [DEFAULT_INDEX_WIDTH-1:0] index;
        logic                           zero;
        logic                           carry;
        logic [DEFAULT_DATA_WIDTH-1:0]  result;
    } result_entry_t;

endpackage

// File: rtl/mest_result_fifo_core.sv
// Generic register-array FIFO with first-word-fall-through head, separate occupancy counter.
// Callers must only assert push_i when there is room (or a pop in the same cycle) and pop_i when non-empty.
module mest_result_fifo_core #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    reset_n_i,
    input  logic                    push_i,
    input  logic                    pop_i,
    input  logic [WIDTH-1:0]        wr_data_i,
    output logic [WIDTH-1:0]        rd_data_o,
    output logic [$clog2(DEPTH):0]  count_o,
    output logic                    full_o,
    output logic                    empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    always_comb begin
        // NOTE: every next-state value gets a default first, so no path can infer a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
        if (!reset_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; count/pointers alone define validity.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= wr_data_i;
    end

    assign rd_data_o = mem_q[rd_ptr_q];
    assign count_o   = count_q;
    assign full_o    = (count_q == CW'(DEPTH));
    assign empty_o   = (count_q == '0);

endmodule

// File: rtl/mest_result_buffer.sv
// Result sink for mest_pro: tags each result beat with a sequence index, buffers it, and tracks drain.
// Optional MEST_RESULT_HIGHWATER_EN adds o_high_water, the peak occupancy since reset.
module mest_result_buffer
    import mest_result_pkg::*;
#(
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int DEPTH       = DEFAULT_DEPTH,
    parameter int INDEX_WIDTH = DEFAULT_INDEX_WIDTH
) (
    input  logic                        clk,
    input  logic                        i_reset_n,
    input  logic [DATA_WIDTH-1:0]       i_result,
    input  logic                        i_valid_result,
    input  logic                        i_carry,
    input  logic                        i_zero_flag,
    input  logic                        i_all_done,
    output logic [DATA_WIDTH+1:0]       o_rd_data,
    output logic [INDEX_WIDTH-1:0]      o_rd_index,
    output logic                        o_rd_valid,
    input  logic                        i_rd_ready,
    output logic [$clog2(DEPTH):0]      o_count,
    output logic                        o_full,
    output logic                        o_empty,
    output logic                        o_overflow,
    output logic [DROP_COUNT_WIDTH-1:0] o_drop_count,
`ifdef MEST_RESULT_HIGHWATER_EN
    output logic [$clog2(DEPTH):0]      o_high_water,
`endif
    output logic                        o_drained
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = INDEX_WIDTH + DATA_WIDTH + 2;

    result_state_e               state_q, state_d;
    logic [INDEX_WIDTH-1:0]      wr_index_q, wr_index_d;
    logic                        overflow_q, overflow_d;
    logic [DROP_COUNT_WIDTH-1:0] drop_count_q, drop_count_d;

    logic          push_req, pop, accept, drop;
    logic [EW-1:0] wr_entry, head_entry;
    logic [CW-1:0] count;
    logic          full, empty;

    assign push_req = i_valid_result && (state_q == COLLECT);
    assign pop      = !empty && i_rd_ready;
    assign accept   = push_req && (!full || pop);
    assign drop     = push_req && !accept;
    assign wr_entry = {wr_index_q, i_zero_flag, i_carry, i_result};

    mest_result_fifo_core #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n_i (i_reset_n),
        .push_i    (accept),
        .pop_i     (pop),
        .wr_data_i (wr_entry),
        .rd_data_o (head_entry),
        .count_o   (count),
        .full_o    (full),
        .empty_o   (empty)
    );

    always_comb begin
        state_d      = state_q;
        wr_index_d   = wr_index_q;
        overflow_d   = overflow_q;
        drop_count_d = drop_count_q;
        // Dropped beats still consume a tag so the consumer can spot the gap.
        if (push_req) wr_index_d = wr_index_q + INDEX_WIDTH'(1);
        if (drop) begin
            overflow_d = 1'b1;
            if (drop_count_q != '1) drop_count_d = drop_count_q + DROP_COUNT_WIDTH'(1);
        end
        case (state_q)
            COLLECT: if (i_all_done) state_d = FLUSH;
            FLUSH:   if (count == '0) state_d = DRAINED;
            DRAINED: state_d = DRAINED;
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!i_reset_n) begin
            state_q      <= COLLECT;
            wr_index_q   <= '0;
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
        end else begin
            state_q      <= state_d;
            wr_index_q   <= wr_index_d;
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
        end
    end

`ifdef MEST_RESULT_HIGHWATER_EN
    logic [CW-1:0] high_water_q, high_water_d;

    assign high_water_d = (count > high_water_q) ? count : high_water_q;

    always_ff @(posedge clk) begin
        if (!i_reset_n) high_water_q <= '0;
        else            high_water_q <= high_water_d;
    end

    assign o_high_water = high_water_q;
`endif

    assign o_rd_valid   = !empty;
    assign o_rd_data    = empty ? '0 : head_entry[DATA_WIDTH+1:0];
    assign o_rd_index   = empty ? '0 : head_entry[EW-1 -: INDEX_WIDTH];
    assign o_count      = count;
    assign o_full       = full;
    assign o_empty      = empty;
    assign o_overflow   = overflow_q;
    assign o_drop_count = drop_count_q;
    assign o_drained    = (state_q == DRAINED);

endmodule

// File: tb/tb_mest_result_buffer.sv
// Scoreboard bench for mest_result_buffer: stimulus queues expected entries, a monitor checks every read.
module tb_mest_result_buffer;
    import mest_result_pkg::*;

    logic        clk = 1'b0;
    logic        i_reset_n = 1'b0;
    logic [7:0]  i_result = '0;
    logic        i_valid_result = 1'b0;
    logic        i_carry = 1'b0;
    logic        i_zero_flag = 1'b0;
    logic        i_all_done = 1'b0;
    logic [9:0]  o_rd_data;
    logic [7:0]  o_rd_index;
    logic        o_rd_valid;
    logic        i_rd_ready = 1'b0;
    logic [4:0]  o_count;
    logic        o_full;
    logic        o_empty;
    logic        o_overflow;
    logic [7:0]  o_drop_count;
    logic        o_drained;
`ifdef MEST_RESULT_HIGHWATER_EN
    logic [4:0]  o_high_water;
`endif

    int checks = 0;
    int errors = 0;
    result_entry_t sb[$];
    logic [7:0] exp_idx = '0;

    always #5 clk = ~clk;

    mest_result_buffer dut (
        .clk            (clk),
        .i_reset_n      (i_reset_n),
        .i_result       (i_result),
        .i_valid_result (i_valid_result),
        .i_carry        (i_carry),
        .i_zero_flag    (i_zero_flag),
        .i_all_done     (i_all_done),
        .o_rd_data      (o_rd_data),
        .o_rd_index     (o_rd_index),
        .o_rd_valid     (o_rd_valid),
        .i_rd_ready     (i_rd_ready),
        .o_count        (o_count),
        .o_full         (o_full),
        .o_empty        (o_empty),
        .o_overflow     (o_overflow),
        .o_drop_count   (o_drop_count),
`ifdef MEST_RESULT_HIGHWATER_EN
        .o_high_water   (o_high_water),
`endif
        .o_drained      (o_drained)
    );

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        i_reset_n      = 1'b0;
        i_valid_result = 1'b0;
        i_all_done     = 1'b0;
        i_rd_ready     = 1'b0;
        tick();
        i_reset_n = 1'b1;
        sb.delete();
        exp_idx = '0;
    endtask

    task automatic push(input logic [7:0] res, input logic z, input logic c,
                        input logic done, input logic exp_accept);
        result_entry_t e;
        i_valid_result = 1'b1;
        i_result       = res;
        i_zero_flag    = z;
        i_carry        = c;
        i_all_done     = done;
        if (exp_accept) begin
            e.index  = exp_idx;
            e.zero   = z;
            e.carry  = c;
            e.result = res;
            sb.push_back(e);
        end
        tick();
        i_valid_result = 1'b0;
        i_all_done     = 1'b0;
        exp_idx        = exp_idx + 8'd1;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        i_rd_ready = 1'b1;
        while (sb.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        i_rd_ready = 1'b0;
        check("drain_done", sb.size(), 0);
    endtask

    // Monitor: compares every accepted read against the scoreboard head.
    initial begin
        result_entry_t e;
        forever begin
            @(negedge clk);
            if (i_reset_n && o_rd_valid && i_rd_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_read: got index %0d data %0h, expected no read", o_rd_index, o_rd_data);
                end else begin
                    e = sb.pop_front();
                    check("rd_index", o_rd_index, e.index);
                    check("rd_data", o_rd_data, {e.zero, e.carry, e.result});
                end
            end
        end
    end

    initial begin
        // Reset state
        do_reset();
        check("rst_valid", o_rd_valid, 0);
        check("rst_empty", o_empty, 1);
        check("rst_full", o_full, 0);
        check("rst_count", o_count, 0);
        check("rst_drained", o_drained, 0);
        check("rst_data_mask", o_rd_data, 0);
        check("rst_index_mask", o_rd_index, 0);
        check("rst_overflow", o_overflow, 0);
        check("rst_drop", o_drop_count, 0);

        // Basic order with the consumer always ready
        i_rd_ready = 1'b1;
        push(8'd5,   1'b0, 1'b0, 1'b0, 1'b1);
        push(8'd0,   1'b1, 1'b0, 1'b0, 1'b1);
        push(8'd255, 1'b0, 1'b1, 1'b0, 1'b1);
        drain(10);
        tick();
        check("basic_count", o_count, 0);
        check("basic_empty", o_empty, 1);

        // Overflow: 18 pushes into 16 entries, consumer stalled
        do_reset();
        for (int i = 0; i < 18; i++) push(8'(i), 1'b0, 1'b0, 1'b0, i < 16);
        check("ovf_full", o_full, 1);
        check("ovf_count", o_count, 16);
        check("ovf_flag", o_overflow, 1);
        check("ovf_drops", o_drop_count, 2);
        tick();
        check("hold_index", o_rd_index, 0);
        check("hold_data", o_rd_data, 0);
        drain(40);
        check("ovf_empty", o_empty, 1);
        check("ovf_sticky", o_overflow, 1);

        // Push and pop in the same cycle while full
        do_reset();
        for (int i = 0; i < 16; i++) push(8'(16 + i), 1'b0, 1'b1, 1'b0, 1'b1);
        check("pp_full", o_full, 1);
        i_rd_ready = 1'b1;
        push(8'hAA, 1'b0, 1'b0, 1'b0, 1'b1);
        i_rd_ready = 1'b0;
        check("pp_count", o_count, 16);
        check("pp_overflow", o_overflow, 0);
        check("pp_drops", o_drop_count, 0);
        drain(40);

        // Done with the 3rd push, then flush and drain
        do_reset();
        push(8'd1, 1'b0, 1'b0, 1'b0, 1'b1);
        push(8'd2, 1'b0, 1'b0, 1'b0, 1'b1);
        push(8'd3, 1'b1, 1'b0, 1'b1, 1'b1);
        push(8'd4, 1'b0, 1'b0, 1'b0, 1'b0);
        check("done_count", o_count, 3);
        check("done_drops", o_drop_count, 0);
        check("done_overflow", o_overflow, 0);
        check("done_not_drained", o_drained, 0);
        i_rd_ready = 1'b1;
        repeat (3) tick();
        i_rd_ready = 1'b0;
        check("done_empty", o_count, 0);
        check("done_drained_lag", o_drained, 0);
        tick();
        check("done_drained", o_drained, 1);
        i_all_done = 1'b1;
        tick();
        i_all_done = 1'b0;
        check("done_stays", o_drained, 1);

        // Reset in the middle of operation
        do_reset();
        for (int i = 0; i < 17; i++) push(8'(40 + i), 1'b0, 1'b0, 1'b0, i < 16);
        i_rd_ready = 1'b1;
        repeat (9) tick();
        i_rd_ready = 1'b0;
        check("mid_count", o_count, 7);
        check("mid_overflow", o_overflow, 1);
        do_reset();
        check("mid_rst_count", o_count, 0);
        check("mid_rst_overflow", o_overflow, 0);
        check("mid_rst_drops", o_drop_count, 0);
        check("mid_rst_empty", o_empty, 1);
        push(8'h77, 1'b1, 1'b1, 1'b0, 1'b1);
        check("mid_first_index", o_rd_index, 0);
        drain(10);

`ifdef MEST_RESULT_HIGHWATER_EN
        // Peak occupancy survives later, smaller bursts
        do_reset();
        for (int i = 0; i < 9; i++) push(8'(i), 1'b0, 1'b0, 1'b0, 1'b1);
        drain(20);
        for (int i = 0; i < 4; i++) push(8'(i), 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        check("high_water", o_high_water, 9);
        drain(20);
`endif

        tick();
        check("final_scoreboard", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
